key_move_encoder: RTL and testbench
===================================

Name: key_move_encoder

Overview:
- Upstream input stage for the sokoban move controller.
- Synchronises and debounces the four active-low push buttons KEY[3:0] and turns presses into single direction commands.
- Supports optional auto-repeat while a button is held.
- Delivers each command through a one-entry valid/ready register, so one physical press produces exactly one move request.

Parameters:
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles needed before a key's debounced level changes (10 ms at 50 MHz). Minimum 2.
- REPEAT_EN, 1: 1 enables auto-repeat; 0 gives one command per press.
- REPEAT_DELAY, 25000000: cycles from a press event to the first repeat event (0.5 s).
- REPEAT_PERIOD, 10000000: cycles between subsequent repeat events (0.2 s).
- CNT_W, 25: counter width. Must hold max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD).

Ports:
- CLOCK_50  input  1  system clock, 50 MHz.
- resetn  input  1  synchronous, active-low reset.
- KEY  input  4  raw push buttons, active-low, asynchronous.
- cmd_valid  output  1  a direction command is held in the output register.
- cmd_ready  input  1  consumer accepts the command; transfer occurs when cmd_valid & cmd_ready.
- cmd_dir  output  2  direction: 0 = right (+x, KEY[0]), 1 = down (+y, KEY[1]), 2 = up (-y, KEY[2]), 3 = left (-x, KEY[3]).
- keys_idle  output  1  all four debounced keys are released.
- overflow  output  1  sticky: an event was dropped because of backpressure.

Behaviour:
- Reset is synchronous, active-low, on clock CLOCK_50.
  - Synchroniser flops and debounced levels reset to 4'b1111.
  - Counters reset to 0; FSM goes to IDLE.
  - cmd_valid=0, cmd_dir=0, keys_idle=1, overflow=0.
  - Reset asserted mid-operation discards any pending command and repeat timing.
- Synchronisation: each KEY bit passes through a 2-flop synchroniser.
- Debounce (per key, independent):
  - Counter increments while the synchronised level differs from the debounced level; it clears whenever they match.
  - When the counter reaches DEBOUNCE_CYCLES-1 with the levels still differing, the debounced level takes the synchronised value on the next edge and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES produces no change.
- Press event: debounced level of a key goes 1 -> 0.
  - If several keys press in the same cycle, the lowest index wins.
  - Lower-priority simultaneous presses are discarded silently and do not set overflow.
- Latency: a raw KEY edge held stable produces cmd_valid=1 exactly 2 + DEBOUNCE_CYCLES + 1 cycles later.
- A key held low through reset deassertion counts as a new press after the same latency.
- Repeat FSM:
  - IDLE: on a press event, latch the tracked key, load timer=REPEAT_DELAY, go to HOLD (only if REPEAT_EN=1; otherwise stay IDLE).
  - HOLD: timer decrements each cycle. At 1, emit a repeat event for the tracked key, reload REPEAT_PERIOD, go to RPT.
  - RPT: same countdown, emits a repeat event every REPEAT_PERIOD cycles.
  - In HOLD or RPT, a debounced release of the tracked key returns to IDLE with no event that cycle.
  - In HOLD or RPT, a new press of another key emits that key's event, retracks to it, reloads REPEAT_DELAY and goes to HOLD.
- Output register:
  - Event with cmd_valid=0, or with cmd_valid & cmd_ready in the same cycle: load cmd_dir and set cmd_valid=1 next cycle. Back-to-back transfers are allowed.
  - Event with cmd_valid=1 and cmd_ready=0: the event is dropped, cmd_dir is unchanged, and overflow is set to 1 (cleared only by reset).
  - Transfer with no new event: cmd_valid=0 next cycle.
  - cmd_dir is stable while cmd_valid=1.
- keys_idle: registered, equal to the AND of the four debounced levels. Replaces the raw KEY==4'b1111 check in the controller.

Decomposition:
- Shared package sokoban_pkg:
  - DIR_RIGHT=0, DIR_DOWN=1, DIR_UP=2, DIR_LEFT=3.
  - KEYS_RELEASED=4'b1111.
  - Repeat FSM state encodings IDLE/HOLD/RPT.
- Sub-module key_debounce, one bit wide with a 2-flop synchroniser plus debounce counter, parameterised by DEBOUNCE_CYCLES and CNT_W. Instantiated 4 times.
- Priority encoder, repeat FSM and output register stay in key_move_encoder.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8, REPEAT_EN=1, and cycles counted from the raw edge.
1. KEY=4'b0111 held stable, cmd_ready=1 -> cmd_valid=1, cmd_dir=3 for exactly one cycle at cycle 7; next repeat at cycle 27.
2. KEY[1] bounces (low 3 cycles, high 1, low steady) -> exactly one command, cmd_dir=1, 7 cycles after the final falling edge; no event from the bounce.
3. cmd_ready=0; press/release KEY[0], then press KEY[2] -> cmd_valid=1 with cmd_dir=0 throughout and overflow=1. Raise cmd_ready -> one transfer, then cmd_valid=0.
4. KEY[0] and KEY[2] fall in the same cycle -> single command cmd_dir=0, overflow stays 0; repeats carry dir 0.
5. Hold KEY[1], cmd_ready=1 -> commands at cycles 7, 27, 35, 43. Release -> no further commands; keys_idle=1 7 cycles after the release edge.
6. resetn=0 for one cycle while cmd_valid=1 and KEY[3] held -> next cycle cmd_valid=0, overflow=0, keys_idle=1. New cmd_dir=3 appears 7 cycles after resetn returns to 1.

Source files
------------

// File: rtl/sokoban_pkg.sv
// rtl/sokoban_pkg.sv - shared direction codes, key constants and repeat FSM states
package sokoban_pkg;

    // Direction codes equal the KEY index that produces them.
    localparam logic [1:0] DIR_RIGHT = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_UP    = 2'd2;
    localparam logic [1:0] DIR_LEFT  = 2'd3;

    localparam logic [3:0] KEYS_RELEASED = 4'b1111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        RPT  = 2'd2
    } rpt_state_e;

    // Lowest set bit wins when several keys press together.
    function automatic logic [1:0] lowest_key(input logic [3:0] v);
        if (v[0])      return DIR_RIGHT;
        else if (v[1]) return DIR_DOWN;
        else if (v[2]) return DIR_UP;
        else           return DIR_LEFT;
    endfunction

endpackage

// File: rtl/key_move_encoder_if.sv
// rtl/key_move_encoder_if.sv - valid/ready direction command channel
// cmd_valid : command held in the output register
// cmd_ready : consumer accepts; transfer on cmd_valid & cmd_ready
// cmd_dir   : 0 right, 1 down, 2 up, 3 left
interface key_move_encoder_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_dir;

    modport master (output cmd_valid, output cmd_dir, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_dir, output cmd_ready);
endinterface

// File: rtl/key_move_encoder_debounce.sv
// rtl/key_move_encoder_debounce.sv - one-bit 2-flop synchroniser plus debounce counter
// CLOCK_50 : clock
// resetn   : synchronous active-low reset
// key_raw  : asynchronous raw key level
// key_db   : debounced level, resets to 1 (released)
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 25
) (
    input  logic CLOCK_50,
    input  logic resetn,
    input  logic key_raw,
    output logic key_db
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             db_q, db_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d = key_raw;
        sync2_d = sync1_q;
        db_d    = db_q;
        cnt_d   = '0;
        // Count only while the levels disagree; any agreement restarts the run.
        if (sync2_q != db_q) begin
            if (cnt_q == CNT_LAST) db_d  = sync2_q;
            else                   cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            db_q    <= 1'b1;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
        end
    end

    assign key_db = db_q;

endmodule

// File: rtl/key_move_encoder.sv
// rtl/key_move_encoder.sv - debounced KEY presses to single direction commands with auto-repeat
// CLOCK_50  : clock
// resetn    : synchronous active-low reset
// KEY       : raw active-low push buttons
// cmd_if    : valid/ready command channel (master side)
// keys_idle : registered, all debounced keys released
// overflow  : sticky, an event was dropped under backpressure
module key_move_encoder
    import sokoban_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_EN       = 1,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 10000000,
    parameter int CNT_W           = 25
) (
    input  logic                CLOCK_50,
    input  logic                resetn,
    input  logic [3:0]          KEY,
    key_move_encoder_if.master  cmd_if,
    output logic                keys_idle,
    output logic                overflow
);
    logic [3:0] db;

    for (genvar i = 0; i < 4; i++) begin : g_db
        key_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_db (
            .CLOCK_50 (CLOCK_50),
            .resetn   (resetn),
            .key_raw  (KEY[i]),
            .key_db   (db[i])
        );
    end

    logic [3:0]       db_prev_q, db_prev_d;
    rpt_state_e       state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic [1:0]       track_q, track_d;
    logic             valid_q, valid_d;
    logic [1:0]       dir_q, dir_d;
    logic             ovf_q, ovf_d;
    logic             idle_q, idle_d;

    logic [3:0] press_evt, rise_evt;
    logic       ev;
    logic [1:0] ev_dir;

    always_comb begin
        db_prev_d = db;
        state_d   = state_q;
        timer_d   = timer_q;
        track_d   = track_q;
        valid_d   = valid_q;
        dir_d     = dir_q;
        ovf_d     = ovf_q;
        idle_d    = (db == KEYS_RELEASED);
        ev        = 1'b0;
        ev_dir    = '0;

        press_evt = db_prev_q & ~db;
        rise_evt  = ~db_prev_q & db;

        // A new press always wins, even over release of the tracked key.
        if (|press_evt) begin
            ev     = 1'b1;
            ev_dir = lowest_key(press_evt);
            if (REPEAT_EN != 0) begin
                track_d = ev_dir;
                timer_d = CNT_W'(REPEAT_DELAY);
                state_d = HOLD;
            end
        end else if (state_q != IDLE) begin
            if (rise_evt[track_q]) begin
                state_d = IDLE;
            end else if (timer_q == CNT_W'(1)) begin
                ev      = 1'b1;
                ev_dir  = track_q;
                timer_d = CNT_W'(REPEAT_PERIOD);
                state_d = RPT;
            end else begin
                timer_d = timer_q - 1'b1;
            end
        end

        // One-entry output register; a blocked event is dropped, not queued.
        if (ev) begin
            if (!valid_q || cmd_if.cmd_ready) begin
                valid_d = 1'b1;
                dir_d   = ev_dir;
            end else begin
                ovf_d = 1'b1;
            end
        end else if (valid_q && cmd_if.cmd_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            db_prev_q <= KEYS_RELEASED;
            state_q   <= IDLE;
            timer_q   <= '0;
            track_q   <= '0;
            valid_q   <= 1'b0;
            dir_q     <= '0;
            ovf_q     <= 1'b0;
            idle_q    <= 1'b1;
        end else begin
            db_prev_q <= db_prev_d;
            state_q   <= state_d;
            timer_q   <= timer_d;
            track_q   <= track_d;
            valid_q   <= valid_d;
            dir_q     <= dir_d;
            ovf_q     <= ovf_d;
            idle_q    <= idle_d;
        end
    end

    assign cmd_if.cmd_valid = valid_q;
    assign cmd_if.cmd_dir   = dir_q;
    assign keys_idle        = idle_q;
    assign overflow         = ovf_q;

endmodule

// File: tb/tb_key_move_encoder.sv
// tb/tb_key_move_encoder.sv - self-checking bench for key_move_encoder
module tb_key_move_encoder;
    localparam int DB    = 4;
    localparam int DLY   = 20;
    localparam int PER   = 8;
    localparam int MAXC  = 8192;

    logic       clk = 1'b0;
    logic       resetn;
    logic [3:0] key;
    logic       ready;
    logic       valid, ovf, idle;
    logic [1:0] dir;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    key_move_encoder_if cmd_if ();
    assign cmd_if.cmd_ready = ready;
    assign valid = cmd_if.cmd_valid;
    assign dir   = cmd_if.cmd_dir;

    key_move_encoder #(
        .DEBOUNCE_CYCLES (DB),
        .REPEAT_EN       (1),
        .REPEAT_DELAY    (DLY),
        .REPEAT_PERIOD   (PER),
        .CNT_W           (8)
    ) dut (
        .CLOCK_50  (clk),
        .resetn    (resetn),
        .KEY       (key),
        .cmd_if    (cmd_if),
        .keys_idle (idle),
        .overflow  (ovf)
    );

    always #5 clk = ~clk;

    // Reference model: raw samples per cycle, debounce as "last DB synchronised
    // samples all disagree", repeat timing as absolute due-cycle numbers.
    logic [3:0] raw_h [0:MAXC-1];
    logic [3:0] samp  [0:MAXC-1];
    int         last_rst = 0;
    logic [3:0] m_deb = 4'hF, m_deb_old = 4'hF;
    bit         tracking = 0;
    int         trk = 0;
    int         next_rep = 0;
    logic       m_valid = 0, m_ovf = 0, m_idle = 1;
    logic [1:0] m_dir = 0;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        logic [3:0] falls, rises, s, nd;
        bit         ev, diff;
        logic [1:0] d;
        raw_h[cyc] = key;
        if (!resetn) begin
            last_rst  = cyc;
            m_deb     = 4'hF;
            m_deb_old = 4'hF;
            tracking  = 0;
            m_valid   = 0;
            m_dir     = 0;
            m_ovf     = 0;
            m_idle    = 1;
            samp[cyc] = 4'hF;
            return;
        end
        falls = m_deb_old & ~m_deb;
        rises = ~m_deb_old & m_deb;
        ev = 0;
        d  = 0;
        if (falls != 0) begin
            for (int k = 3; k >= 0; k--) if (falls[k]) d = 2'(k);
            ev = 1; tracking = 1; trk = d; next_rep = cyc + DLY;
        end else if (tracking && rises[trk]) begin
            tracking = 0;
        end else if (tracking && cyc == next_rep) begin
            ev = 1; d = 2'(trk); next_rep = cyc + PER;
        end
        if (ev) begin
            if (!m_valid || ready) begin m_valid = 1; m_dir = d; end
            else m_ovf = 1;
        end else if (m_valid && ready) begin
            m_valid = 0;
        end
        m_idle = (m_deb == 4'hF);
        s = (cyc - 2 > last_rst) ? raw_h[cyc-2] : 4'hF;
        samp[cyc] = s;
        nd = m_deb;
        if (cyc - DB + 1 > last_rst) begin
            for (int k = 0; k < 4; k++) begin
                diff = 1;
                for (int j = cyc - DB + 1; j <= cyc; j++)
                    if (samp[j][k] == m_deb[k]) diff = 0;
                if (diff) nd[k] = ~m_deb[k];
            end
        end
        m_deb_old = m_deb;
        m_deb     = nd;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        cyc++;
        #1;
        check($sformatf("cycle%0d", cyc), {3'b0, valid, dir, ovf, idle},
              {3'b0, m_valid, m_dir, m_ovf, m_idle});
    endtask

    initial begin
        resetn = 0; key = 4'hF; ready = 1;
        tick(); tick();
        check("reset_state", {3'b0, valid, dir, ovf, idle}, 8'b0000_0001);
        resetn = 1;
        repeat (10) tick();

        // 1: KEY[3] held, ready high
        key = 4'b0111;
        repeat (6) tick();
        check("t1_before", {7'b0, valid}, 8'd0);
        tick();
        check("t1_cmd", {5'b0, valid, dir}, 8'b111);
        tick();
        check("t1_one_cycle", {7'b0, valid}, 8'd0);
        repeat (19) tick();
        check("t1_repeat27", {5'b0, valid, dir}, 8'b111);
        key = 4'hF;
        repeat (15) tick();

        // 2: KEY[1] bounce
        key = 4'b1101; repeat (3) tick();
        key = 4'b1111; tick();
        key = 4'b1101;
        repeat (6) tick();
        check("t2_before", {7'b0, valid}, 8'd0);
        tick();
        check("t2_cmd", {5'b0, valid, dir}, 8'b101);
        key = 4'hF;
        repeat (15) tick();

        // 3: backpressure drops events and sets overflow
        ready = 0;
        key = 4'b1110; repeat (10) tick();
        key = 4'b1111; repeat (10) tick();
        key = 4'b1011; repeat (10) tick();
        check("t3_held", {5'b0, valid, dir, ovf}, 8'b1001);
        key = 4'hF; ready = 1;
        tick();
        check("t3_transfer", {7'b0, valid}, 8'd0);
        repeat (2) tick();
        check("t3_sticky", {6'b0, valid, ovf}, 8'b01);
        resetn = 0; tick(); resetn = 1;
        repeat (3) tick();

        // 4: simultaneous KEY[0] and KEY[2]
        key = 4'b1010;
        repeat (7) tick();
        check("t4_cmd", {5'b0, valid, dir, ovf}, 8'b1000);
        tick();
        repeat (19) tick();
        check("t4_repeat", {5'b0, valid, dir, ovf}, 8'b1000);
        key = 4'hF;
        repeat (15) tick();
        check("t4_no_ovf", {7'b0, ovf}, 8'd0);

        // 5: KEY[1] held, repeats then release
        key = 4'b1101;
        repeat (7) tick();
        check("t5_c7", {5'b0, valid, dir}, 8'b101);
        repeat (20) tick();
        check("t5_c27", {5'b0, valid, dir}, 8'b101);
        repeat (8) tick();
        check("t5_c35", {5'b0, valid, dir}, 8'b101);
        repeat (8) tick();
        check("t5_c43", {5'b0, valid, dir}, 8'b101);
        key = 4'hF;
        repeat (6) tick();
        check("t5_idle_early", {7'b0, idle}, 8'd0);
        tick();
        check("t5_idle", {7'b0, idle}, 8'd1);
        repeat (15) tick();
        check("t5_no_more", {7'b0, valid}, 8'd0);

        // 6: reset while a command is pending and KEY[3] held
        ready = 0;
        key = 4'b0111;
        repeat (7) tick();
        check("t6_pending", {5'b0, valid, dir}, 8'b111);
        resetn = 0; tick();
        check("t6_reset", {5'b0, valid, ovf, idle}, 8'b001);
        resetn = 1;
        repeat (6) tick();
        check("t6_before", {7'b0, valid}, 8'd0);
        tick();
        check("t6_cmd", {5'b0, valid, dir}, 8'b111);
        key = 4'hF; ready = 1;
        repeat (15) tick();

        // Randomised phase against the model
        for (int i = 0; i < 200; i++) begin
            int r, len;
            r = $urandom_range(0, 9);
            if (r < 4)       key = ~(4'b0001 << r);
            else if (r < 6)  key = 4'($urandom);
            else             key = 4'hF;
            len = $urandom_range(1, 30);
            for (int c = 0; c < len; c++) begin
                ready = ($urandom_range(0, 3) != 0);
                tick();
            end
            if ($urandom_range(0, 49) == 0) begin
                resetn = 0; tick(); resetn = 1;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
